offchip_link_arbiter: RTL and testbench

- Shares one 4-bit, credit-controlled off-chip link between two 8-bit byte requesters.
- Arbitrates per byte, using round-robin or fixed priority.
- Splits the granted byte into two 4-bit beats, low nibble first, and tags each beat with its source.
- Tracks beat-buffer credits at the far end and never overruns them. It sits between the byte producers and the off-chip nibble buffer.

---
 rtl/offchip_link_arbiter_pkg.sv | 17 +
 rtl/offchip_link_arbiter_if.sv | 39 +++
 rtl/offchip_link_arbiter_link_credit_counter.sv | 44 ++++
 rtl/offchip_link_arbiter.sv | 105 ++++++++++
 tb/tb_offchip_link_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/offchip_link_arbiter_pkg.sv
// Shared types and widths for the off-chip link arbiter: byte/beat/source
// widths, default credit depth and the beat sequencer state encoding.
package offchip_link_arbiter_pkg;

    localparam int BYTE_W      = 8;
    localparam int BEAT_W      = 4;
    localparam int SRC_W       = 1;
    localparam int CREDITS_DEF = 8;
    localparam int CNT_W_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

endpackage

// File: rtl/offchip_link_arbiter_if.sv
// Requester, link and credit signals of the arbiter; the slave modport is the
// arbiter's view, the master modport is the environment's view.
interface offchip_link_arbiter_if
    import offchip_link_arbiter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic              req0_valid;
    logic [BYTE_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [BYTE_W-1:0] req1_data;
    logic              req1_ready;
    logic              prio_mode;
    logic              link_valid;
    logic [BEAT_W-1:0] link_data;
    logic [SRC_W-1:0]  link_src;
    logic              link_last;
    logic              credit_ret;
    logic [CNT_W-1:0]  credits_avail;
    logic              credit_err;

    // Requesters: a byte moves on the cycle where valid and ready are both 1;
    // ready is only ever raised when valid is already high. The link has no
    // backpressure: every cycle with link_valid=1 is one delivered beat.
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, prio_mode, credit_ret,
        output req0_ready, req1_ready, link_valid, link_data, link_src, link_last,
        output credits_avail, credit_err
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, prio_mode, credit_ret,
        input  req0_ready, req1_ready, link_valid, link_data, link_src, link_last,
        input  credits_avail, credit_err
    );

endinterface

// File: rtl/offchip_link_arbiter_link_credit_counter.sv
// Far-end beat-slot credit counter with the two sufficiency compares used by
// the arbiter's accept window and a sticky over-return flag.
module link_credit_counter #(
    parameter int CREDITS = 8,
    parameter int CNT_W   = 4   // 2**CNT_W must exceed CREDITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_beat,
    input  logic             i_credit_ret,
    output logic [CNT_W-1:0] o_credits,
    output logic             o_ok_idle,
    output logic             o_ok_beat1,
    output logic             o_err
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= FULL;
            r_err <= 1'b0;
        end else begin
            case ({i_beat, i_credit_ret})
                2'b10:   r_cnt <= r_cnt - CNT_W'(1);
                2'b01: begin
                    if (r_cnt == FULL) r_err <= 1'b1;
                    else               r_cnt <= r_cnt + CNT_W'(1);
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // In BEAT1 the beat on the wire has not been deducted yet, hence one extra.
    assign o_ok_idle  = (r_cnt >= CNT_W'(2));
    assign o_ok_beat1 = (r_cnt >= CNT_W'(3));
    assign o_credits  = r_cnt;
    assign o_err      = r_err;

endmodule

// File: rtl/offchip_link_arbiter.sv
// Two-requester byte arbiter feeding a credit-controlled 4-bit link; each
// granted byte goes out as a low-nibble beat followed by a high-nibble beat.
module offchip_link_arbiter
    import offchip_link_arbiter_pkg::*;
#(
    parameter int CREDITS = CREDITS_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    offchip_link_arbiter_if.slave io_bus,
    output state_t                o_state
);

    state_t            r_state;
    logic              r_last_grant;
    logic [BEAT_W-1:0] r_hi;
    logic              r_link_valid;
    logic [BEAT_W-1:0] r_link_data;
    logic [SRC_W-1:0]  r_link_src;
    logic              r_link_last;

    logic              w_ok_idle;
    logic              w_ok_beat1;
    logic              w_window;
    logic              w_accept;
    logic              w_win;
    logic [BYTE_W-1:0] w_win_data;

    assign w_window = ((r_state == IDLE)  && w_ok_idle) ||
                      ((r_state == BEAT1) && w_ok_beat1);
    assign w_accept = !rst && w_window && (io_bus.req0_valid || io_bus.req1_valid);

    always_comb begin
        w_win = io_bus.req1_valid;
        if (io_bus.req0_valid && io_bus.req1_valid)
            w_win = io_bus.prio_mode ? 1'b0 : ~r_last_grant;
    end

    assign w_win_data        = w_win ? io_bus.req1_data : io_bus.req0_data;
    assign io_bus.req0_ready = w_accept && !w_win;
    assign io_bus.req1_ready = w_accept &&  w_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_hi         <= '0;
            r_link_valid <= 1'b0;
            r_link_data  <= '0;
            r_link_src   <= '0;
            r_link_last  <= 1'b0;
        end else begin
            case (r_state)
                BEAT0: begin
                    r_state     <= BEAT1;
                    r_link_data <= r_hi;
                    r_link_last <= 1'b1;
                end
                IDLE, BEAT1: begin
                    if (w_accept) begin
                        r_state      <= BEAT0;
                        r_last_grant <= w_win;
                        r_hi         <= w_win_data[BYTE_W-1:BEAT_W];
                        r_link_valid <= 1'b1;
                        r_link_data  <= w_win_data[BEAT_W-1:0];
                        r_link_src   <= SRC_W'(w_win);
                        r_link_last  <= 1'b0;
                    end else begin
                        r_state      <= IDLE;
                        r_link_valid <= 1'b0;
                        r_link_data  <= '0;
                        r_link_src   <= '0;
                        r_link_last  <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_link_valid <= 1'b0;
                end
            endcase
        end
    end

    link_credit_counter #(
        .CREDITS (CREDITS),
        .CNT_W   (CNT_W)
    ) u_credit (
        .clk          (clk),
        .rst          (rst),
        .i_beat       (r_link_valid),
        .i_credit_ret (io_bus.credit_ret),
        .o_credits    (io_bus.credits_avail),
        .o_ok_idle    (w_ok_idle),
        .o_ok_beat1   (w_ok_beat1),
        .o_err        (io_bus.credit_err)
    );

    assign io_bus.link_valid = r_link_valid;
    assign io_bus.link_data  = r_link_data;
    assign io_bus.link_src   = r_link_src;
    assign io_bus.link_last  = r_link_last;
    assign o_state           = r_state;

endmodule

// File: tb/tb_offchip_link_arbiter.sv
// Bench for offchip_link_arbiter: table of single-byte arbitration cases plus
// hand-written back-to-back, exhaustion, credit and reset sequences.
module tb_offchip_link_arbiter;
    import offchip_link_arbiter_pkg::*;

    localparam int CREDITS = 8;
    localparam int CNT_W   = 4;

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;

    always #5 clk = ~clk;

    offchip_link_arbiter_if #(.CNT_W(CNT_W)) bus ();

    offchip_link_arbiter #(.CREDITS(CREDITS), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .io_bus  (bus),
        .o_state (dbg_state)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         wrap_seen = 0;
    logic [5:0] exp_q[$];
    logic [5:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every beat on the link is matched against the scoreboard, {src,last,nibble}.
    always @(negedge clk) begin
        if (bus.credits_avail > CNT_W'(CREDITS)) wrap_seen++;
        if (bus.link_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got %0h expected none",
                         {bus.link_src, bus.link_last, bus.link_data});
            end else begin
                mon_exp = exp_q.pop_front();
                check("beat", {26'd0, bus.link_src, bus.link_last, bus.link_data}, {26'd0, mon_exp});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic src, input logic [7:0] b);
        exp_q.push_back({src, 1'b0, b[3:0]});
        exp_q.push_back({src, 1'b1, b[7:4]});
    endtask

    task automatic return_credits(input int n);
        for (int i = 0; i < n; i++) begin
            bus.credit_ret = 1'b1;
            step();
        end
        bus.credit_ret = 1'b0;
    endtask

    typedef struct {
        logic       prio;
        logic       v0;
        logic       v1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       r0;
        logic       r1;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[9];

    logic [7:0]  bytes0[2];
    logic [7:0]  bytes1[2];
    logic [11:0] trace;
    logic [3:0]  grants;
    int          i0, i1, ng, both_err, r1_cnt, g0, rdy_seen;

    initial begin
        // last_grant starts at 1 after reset, so round-robin picks req0 first.
        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0, 8'hA5};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 8'h3C, 8'h96, 1'b0, 1'b1, 8'h96};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h11, 8'hE7, 1'b1, 1'b0, 8'h11};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 8'h42, 8'h81, 1'b1, 1'b0, 8'h42};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h5F, 1'b0, 1'b1, 8'h5F};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b1, 8'hC3};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 8'h7E, 8'h29, 1'b1, 1'b0, 8'h7E};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 8'hF0, 8'h0F, 1'b1, 1'b0, 8'hF0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h00};

        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_data  = 8'h00;
        bus.req1_data  = 8'h00;
        bus.prio_mode  = 1'b0;
        bus.credit_ret = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("rst_link_valid", bus.link_valid, 1'b0);
        check("rst_link_data", bus.link_data, 4'h0);
        check("rst_link_src", bus.link_src, 1'b0);
        check("rst_link_last", bus.link_last, 1'b0);
        check("rst_credits", bus.credits_avail, CREDITS);
        check("rst_credit_err", bus.credit_err, 1'b0);
        check("rst_state", dbg_state, IDLE);
        check("rst_ready0", bus.req0_ready, 1'b0);
        check("rst_ready1", bus.req1_ready, 1'b0);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst = 1'b0;

        // Single-byte arbitration table, each starting idle with full credits.
        for (int v = 0; v < 9; v++) begin
            step();
            bus.prio_mode  = vecs[v].prio;
            bus.req0_valid = vecs[v].v0;
            bus.req1_valid = vecs[v].v1;
            bus.req0_data  = vecs[v].d0;
            bus.req1_data  = vecs[v].d1;
            @(negedge clk);
            check($sformatf("vec%0d_ready0", v), bus.req0_ready, vecs[v].r0);
            check($sformatf("vec%0d_ready1", v), bus.req1_ready, vecs[v].r1);
            if (vecs[v].r0 || vecs[v].r1) push_byte(vecs[v].r1, vecs[v].exp_byte);
            step();
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            if (vecs[v].r0 || vecs[v].r1) begin
                step();
                step();
                @(negedge clk);
                check($sformatf("vec%0d_credits_used", v), bus.credits_avail, CREDITS - 2);
                step();
                return_credits(2);
            end
            @(negedge clk);
            check($sformatf("vec%0d_credits", v), bus.credits_avail, CREDITS);
            check($sformatf("vec%0d_state", v), dbg_state, IDLE);
        end

        // Back-to-back round robin from reset, then run the credits dry.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bytes0[0] = 8'h10; bytes0[1] = 8'h32;
        bytes1[0] = 8'h54; bytes1[1] = 8'h76;
        push_byte(1'b0, 8'h10);
        push_byte(1'b1, 8'h54);
        push_byte(1'b0, 8'h32);
        push_byte(1'b1, 8'h76);
        i0 = 0; i1 = 0; ng = 0; both_err = 0; trace = '0; grants = '0;
        bus.prio_mode  = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_data  = bytes0[0];
        bus.req1_data  = bytes1[0];
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            trace[c] = bus.link_valid;
            if (bus.req0_ready && bus.req1_ready) both_err++;
            if (bus.req0_ready) begin i0++; if (ng < 4) grants[ng] = 1'b0; ng++; end
            if (bus.req1_ready) begin i1++; if (ng < 4) grants[ng] = 1'b1; ng++; end
            if (c == 11) check("b2b_credits_zero", bus.credits_avail, 0);
            step();
            bus.req0_valid = (i0 < 2);
            bus.req1_valid = (i1 < 2);
            bus.req0_data  = (i0 < 2) ? bytes0[i0] : 8'h00;
            bus.req1_data  = (i1 < 2) ? bytes1[i1] : 8'h00;
        end
        check("b2b_trace", trace, 12'h1FE);
        check("b2b_grants", grants, 4'b1010);
        check("b2b_grant_count", ng, 4);
        check("b2b_both_ready", both_err, 0);

        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h9B;
        rdy_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.req0_ready) rdy_seen++;
            step();
        end
        check("exhaust_no_ready", rdy_seen, 0);
        bus.credit_ret = 1'b1;
        step();
        bus.credit_ret = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.req0_ready) rdy_seen++;
            step();
        end
        check("one_credit_no_ready", rdy_seen, 0);
        bus.credit_ret = 1'b1;
        @(negedge clk);
        check("ret_cycle_not_counted", bus.req0_ready, 1'b0);
        step();
        bus.credit_ret = 1'b0;
        @(negedge clk);
        check("two_credits_ready", bus.req0_ready, 1'b1);
        push_byte(1'b0, 8'h9B);
        step();
        bus.req0_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        check("refill_credits_zero", bus.credits_avail, 0);
        step();
        return_credits(8);
        @(negedge clk);
        check("refill_credits_full", bus.credits_avail, CREDITS);

        // Fixed priority with both valid: req0 takes both bytes.
        step();
        push_byte(1'b0, 8'h1A);
        push_byte(1'b0, 8'h2B);
        g0 = 0; r1_cnt = 0;
        bus.prio_mode  = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_data  = 8'h1A;
        bus.req1_data  = 8'hEE;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.req1_ready) r1_cnt++;
            if (bus.req0_ready) g0++;
            step();
            bus.req0_valid = (g0 < 2);
            bus.req1_valid = (g0 < 2);
            bus.req0_data  = (g0 == 0) ? 8'h1A : 8'h2B;
        end
        check("prio_req0_grants", g0, 2);
        check("prio_req1_ready", r1_cnt, 0);
        @(negedge clk);
        check("prio_credits", bus.credits_avail, CREDITS - 4);
        step();
        bus.prio_mode = 1'b0;
        return_credits(4);

        // Credit return during a beat, then over-return while idle and full.
        step();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h3D;
        @(negedge clk);
        check("conc_ready0", bus.req0_ready, 1'b1);
        push_byte(1'b0, 8'h3D);
        step();
        bus.req0_valid = 1'b0;
        bus.credit_ret = 1'b1;
        step();
        bus.credit_ret = 1'b0;
        @(negedge clk);
        check("conc_credits_unchanged", bus.credits_avail, CREDITS);
        check("conc_no_err", bus.credit_err, 1'b0);
        step();
        @(negedge clk);
        check("conc_credits_after", bus.credits_avail, CREDITS - 1);
        step();
        return_credits(1);
        @(negedge clk);
        check("conc_credits_refill", bus.credits_avail, CREDITS);
        check("conc_err_still_clear", bus.credit_err, 1'b0);
        step();
        return_credits(1);
        @(negedge clk);
        check("ovf_credits", bus.credits_avail, CREDITS);
        check("ovf_err_set", bus.credit_err, 1'b1);
        repeat (3) step();
        @(negedge clk);
        check("ovf_err_sticky", bus.credit_err, 1'b1);

        // Reset during BEAT0: only the low nibble may ever appear.
        step();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'hC4;
        @(negedge clk);
        check("rstmid_ready0", bus.req0_ready, 1'b1);
        exp_q.push_back({1'b0, 1'b0, 4'h4});
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check("rstmid_link_valid", bus.link_valid, 1'b0);
        check("rstmid_credits", bus.credits_avail, CREDITS);
        check("rstmid_state", dbg_state, IDLE);
        check("rstmid_err_cleared", bus.credit_err, 1'b0);
        check("rstmid_ready_forced", bus.req0_ready, 1'b0);
        step();
        bus.req0_valid = 1'b0;
        rst = 1'b0;
        repeat (4) step();

        check("queue_drained", exp_q.size(), 0);
        check("credits_never_wrap", wrap_seen, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
